// File: rtl/sdram_port_arbiter_if.sv
// rtl/sdram_port_arbiter_if.sv - two requester ports plus the shared SDRAM core request port
interface sdram_port_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH/8-1:0] p0_wr_i;
    logic                    p0_rd_i;
    logic [7:0]              p0_len_i;
    logic [ADDR_WIDTH-1:0]   p0_addr_i;
    logic [DATA_WIDTH-1:0]   p0_write_data_i;
    logic                    p0_accept_o;
    logic                    p0_ack_o;
    logic                    p0_error_o;
    logic [DATA_WIDTH-1:0]   p0_read_data_o;

    logic [DATA_WIDTH/8-1:0] p1_wr_i;
    logic                    p1_rd_i;
    logic [7:0]              p1_len_i;
    logic [ADDR_WIDTH-1:0]   p1_addr_i;
    logic [DATA_WIDTH-1:0]   p1_write_data_i;
    logic                    p1_accept_o;
    logic                    p1_ack_o;
    logic                    p1_error_o;
    logic [DATA_WIDTH-1:0]   p1_read_data_o;

    logic [DATA_WIDTH/8-1:0] ram_wr_o;
    logic                    ram_rd_o;
    logic [7:0]              ram_len_o;
    logic [ADDR_WIDTH-1:0]   ram_addr_o;
    logic [DATA_WIDTH-1:0]   ram_write_data_o;
    logic                    ram_accept_i;
    logic                    ram_ack_i;
    logic                    ram_error_i;
    logic [DATA_WIDTH-1:0]   ram_read_data_i;

    // The arbiter side.
    modport slave (
        input  p0_wr_i, p0_rd_i, p0_len_i, p0_addr_i, p0_write_data_i,
        output p0_accept_o, p0_ack_o, p0_error_o, p0_read_data_o,
        input  p1_wr_i, p1_rd_i, p1_len_i, p1_addr_i, p1_write_data_i,
        output p1_accept_o, p1_ack_o, p1_error_o, p1_read_data_o,
        output ram_wr_o, ram_rd_o, ram_len_o, ram_addr_o, ram_write_data_o,
        input  ram_accept_i, ram_ack_i, ram_error_i, ram_read_data_i
    );

    // The environment side: both requesters and the SDRAM core.
    modport master (
        output p0_wr_i, p0_rd_i, p0_len_i, p0_addr_i, p0_write_data_i,
        input  p0_accept_o, p0_ack_o, p0_error_o, p0_read_data_o,
        output p1_wr_i, p1_rd_i, p1_len_i, p1_addr_i, p1_write_data_i,
        input  p1_accept_o, p1_ack_o, p1_error_o, p1_read_data_o,
        input  ram_wr_o, ram_rd_o, ram_len_o, ram_addr_o, ram_write_data_o,
        output ram_accept_i, ram_ack_i, ram_error_i, ram_read_data_i
    );
endinterface

// File: rtl/sdram_port_arbiter.sv
// rtl/sdram_port_arbiter.sv - round-robin burst arbiter sharing one SDRAM core port between two requesters
module sdram_port_arbiter #(
    parameter int ADDR_WIDTH    = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int OUTSTANDING_W = 4
) (
    input  logic                   ACLK,
    input  logic                   ARSTN,
    sdram_port_arbiter_if.slave    bus
);
    localparam int STRB_W = DATA_WIDTH / 8;

    typedef enum logic [1:0] {ST_IDLE, ST_BURST, ST_DRAIN} state_t;

    state_t                   state;
    logic                     grant;
    logic                     last_grant;
    logic [8:0]               beats_left;
    logic [OUTSTANDING_W-1:0] outstanding;
    logic [OUTSTANDING_W-1:0] outstanding_nxt;

    logic                  p0_req, p1_req, next_grant;
    logic [7:0]            grant_len;
    logic [STRB_W-1:0]     sel_wr, fwd_wr;
    logic                  sel_rd, fwd_rd;
    logic                  in_burst, saturated, beat_taken, resp_route, ack_taken;

    assign p0_req     = (|bus.p0_wr_i) | bus.p0_rd_i;
    assign p1_req     = (|bus.p1_wr_i) | bus.p1_rd_i;
    assign next_grant = (p0_req && p1_req) ? ~last_grant : p1_req;
    assign grant_len  = next_grant ? bus.p1_len_i : bus.p0_len_i;

    assign sel_wr    = grant ? bus.p1_wr_i : bus.p0_wr_i;
    assign sel_rd    = grant ? bus.p1_rd_i : bus.p0_rd_i;
    assign in_burst  = (state == ST_BURST);
    assign saturated = &outstanding;

    // Only the strobes are stalled on saturation; the core ignores the rest without wr/rd.
    assign fwd_wr = (in_burst && !saturated) ? sel_wr : '0;
    assign fwd_rd = in_burst && !saturated && sel_rd;

    assign bus.ram_wr_o         = fwd_wr;
    assign bus.ram_rd_o         = fwd_rd;
    assign bus.ram_len_o        = in_burst ? (grant ? bus.p1_len_i : bus.p0_len_i) : 8'd0;
    assign bus.ram_addr_o       = in_burst ? (grant ? bus.p1_addr_i : bus.p0_addr_i) : '0;
    assign bus.ram_write_data_o = in_burst ? (grant ? bus.p1_write_data_i : bus.p0_write_data_i) : '0;

    assign beat_taken = ((|fwd_wr) | fwd_rd) & bus.ram_accept_i;
    // Responses with nothing in flight are spurious and never reach a port.
    assign resp_route = (state != ST_IDLE) && ((outstanding != '0) || beat_taken);
    assign ack_taken  = resp_route & bus.ram_ack_i;

    assign bus.p0_accept_o    = beat_taken & ~grant;
    assign bus.p1_accept_o    = beat_taken & grant;
    assign bus.p0_ack_o       = ack_taken & ~grant;
    assign bus.p1_ack_o       = ack_taken & grant;
    assign bus.p0_error_o     = resp_route & bus.ram_error_i & ~grant;
    assign bus.p1_error_o     = resp_route & bus.ram_error_i & grant;
    assign bus.p0_read_data_o = (resp_route && !grant) ? bus.ram_read_data_i : '0;
    assign bus.p1_read_data_o = (resp_route && grant) ? bus.ram_read_data_i : '0;

    always_comb begin
        outstanding_nxt = outstanding;
        case ({beat_taken, ack_taken})
            2'b10:   outstanding_nxt = outstanding + OUTSTANDING_W'(1);
            2'b01:   outstanding_nxt = outstanding - OUTSTANDING_W'(1);
            default: outstanding_nxt = outstanding;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (!ARSTN) begin
            state       <= ST_IDLE;
            grant       <= 1'b0;
            last_grant  <= 1'b1;
            beats_left  <= 9'd0;
            outstanding <= '0;
        end else begin
            outstanding <= outstanding_nxt;
            case (state)
                ST_IDLE: begin
                    if (p0_req || p1_req) begin
                        grant      <= next_grant;
                        beats_left <= {1'b0, grant_len} + 9'd1;
                        state      <= ST_BURST;
                    end
                end
                ST_BURST: begin
                    if (beat_taken) begin
                        beats_left <= beats_left - 9'd1;
                        if (beats_left == 9'd1) state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (outstanding_nxt == '0) begin
                        last_grant <= grant;
                        state      <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sdram_port_arbiter.sv
// tb/tb_sdram_port_arbiter.sv - directed vector bench for sdram_port_arbiter
module tb_sdram_port_arbiter;
    logic clk = 1'b0;
    logic arstn;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    sdram_port_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    sdram_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .OUTSTANDING_W(4)) dut (
        .ACLK  (clk),
        .ARSTN (arstn),
        .bus   (bus.slave)
    );

    typedef struct {
        int unsigned p0_rd, p0_wr, p0_len, p1_rd, p1_wr, p1_len, acc, ack, rdata;
        int unsigned e_rd, e_wr, e_addr, e_a0, e_k0, e_a1, e_k1, e_d0, e_d1;
    } vec_t;

    vec_t vec [22];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic p0rd, input logic p1rd, input logic [3:0] p1wr,
                         input logic acc, input logic ack, input logic [31:0] rdata);
        bus.p0_rd_i = p0rd;
        bus.p1_rd_i = p1rd;
        bus.p1_wr_i = p1wr;
        bus.ram_accept_i = acc;
        bus.ram_ack_i = ack;
        bus.ram_read_data_i = rdata;
    endtask

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int beats, acks, p1_acks, first_fwd;
        logic [2:0] sh;
        logic taken;

        arstn = 1'b0;
        bus.p0_wr_i = '0; bus.p0_len_i = '0; bus.p0_addr_i = 32'h100; bus.p0_write_data_i = 32'hA0A0;
        bus.p1_len_i = '0; bus.p1_addr_i = 32'h200; bus.p1_write_data_i = 32'hB1B1;
        bus.ram_error_i = 1'b0;
        drive(1'b1, 1'b1, 4'h0, 1'b1, 1'b1, 32'h55);
        repeat (2) @(posedge clk);
        #5;
        chk("reset_ram_rd", 32'(bus.ram_rd_o), 0);
        chk("reset_ram_wr", 32'(bus.ram_wr_o), 0);
        chk("reset_ram_addr", bus.ram_addr_o, 0);
        chk("reset_ram_len", 32'(bus.ram_len_o), 0);
        chk("reset_acks", {28'd0, bus.p0_ack_o, bus.p1_ack_o, bus.p0_accept_o, bus.p1_accept_o}, 0);
        chk("reset_rdata", bus.p0_read_data_o | bus.p1_read_data_o, 0);
        next_cycle();
        arstn = 1'b1;

        //          p0rd wr len p1rd wr len acc ack rdata  e_rd e_wr e_addr a0 k0 a1 k1 d0 d1
        vec[0]  = '{1, 0, 1, 0, 0,   0, 1, 0, 0,     0, 0,   0,     0, 0, 0, 0, 0,     0};
        vec[1]  = '{1, 0, 1, 0, 0,   0, 1, 0, 0,     1, 0,   'h100, 1, 0, 0, 0, 0,     0};
        vec[2]  = '{1, 0, 1, 0, 0,   0, 1, 1, 'hAA,  1, 0,   'h100, 1, 1, 0, 0, 'hAA,  0};
        vec[3]  = '{0, 0, 0, 0, 0,   0, 0, 1, 'hBB,  0, 0,   0,     0, 1, 0, 0, 'hBB,  0};
        vec[4]  = '{1, 0, 0, 1, 0,   0, 1, 0, 0,     0, 0,   0,     0, 0, 0, 0, 0,     0};
        vec[5]  = '{1, 0, 0, 1, 0,   0, 1, 0, 0,     1, 0,   'h200, 0, 0, 1, 0, 0,     0};
        vec[6]  = '{1, 0, 0, 1, 0,   0, 1, 1, 'h66,  0, 0,   0,     0, 0, 0, 1, 0,     'h66};
        vec[7]  = '{1, 0, 0, 1, 0,   0, 1, 0, 0,     0, 0,   0,     0, 0, 0, 0, 0,     0};
        vec[8]  = '{1, 0, 0, 1, 0,   0, 1, 0, 0,     1, 0,   'h100, 1, 0, 0, 0, 0,     0};
        vec[9]  = '{1, 0, 0, 1, 0,   0, 0, 1, 'h99,  0, 0,   0,     0, 1, 0, 0, 'h99,  0};
        vec[10] = '{0, 0, 0, 0, 0,   0, 1, 1, 'h10,  0, 0,   0,     0, 0, 0, 0, 0,     0};
        vec[11] = '{0, 0, 0, 0, 'hF, 2, 0, 0, 0,     0, 0,   0,     0, 0, 0, 0, 0,     0};
        vec[12] = '{0, 0, 0, 0, 'hF, 2, 0, 0, 0,     0, 'hF, 'h200, 0, 0, 0, 0, 0,     0};
        vec[13] = '{1, 0, 0, 0, 'hF, 2, 0, 0, 0,     0, 'hF, 'h200, 0, 0, 0, 0, 0,     0};
        vec[14] = '{1, 0, 0, 0, 0,   2, 1, 0, 0,     0, 0,   'h200, 0, 0, 0, 0, 0,     0};
        vec[15] = '{1, 0, 0, 0, 'hF, 2, 1, 0, 0,     0, 'hF, 'h200, 0, 0, 1, 0, 0,     0};
        vec[16] = '{1, 0, 0, 0, 'hF, 2, 1, 1, 'h16,  0, 'hF, 'h200, 0, 0, 1, 1, 0,     'h16};
        vec[17] = '{1, 0, 0, 0, 'hF, 2, 1, 0, 0,     0, 'hF, 'h200, 0, 0, 1, 0, 0,     0};
        vec[18] = '{1, 0, 0, 0, 0,   0, 1, 1, 'h18,  0, 0,   0,     0, 0, 0, 1, 0,     'h18};
        vec[19] = '{0, 0, 0, 0, 0,   0, 0, 1, 'h19,  0, 0,   0,     0, 0, 0, 1, 0,     'h19};
        vec[20] = '{1, 0, 0, 0, 0,   0, 1, 0, 0,     0, 0,   0,     0, 0, 0, 0, 0,     0};
        vec[21] = '{1, 0, 0, 0, 0,   0, 1, 0, 0,     1, 0,   'h100, 1, 0, 0, 0, 0,     0};

        for (int i = 0; i < 22; i++) begin
            bus.p0_rd_i = vec[i].p0_rd[0];
            bus.p0_wr_i = vec[i].p0_wr[3:0];
            bus.p0_len_i = vec[i].p0_len[7:0];
            bus.p1_rd_i = vec[i].p1_rd[0];
            bus.p1_wr_i = vec[i].p1_wr[3:0];
            bus.p1_len_i = vec[i].p1_len[7:0];
            bus.ram_accept_i = vec[i].acc[0];
            bus.ram_ack_i = vec[i].ack[0];
            bus.ram_read_data_i = vec[i].rdata;
            #4;
            chk($sformatf("v%0d_ram_rd", i), 32'(bus.ram_rd_o), vec[i].e_rd);
            chk($sformatf("v%0d_ram_wr", i), 32'(bus.ram_wr_o), vec[i].e_wr);
            chk($sformatf("v%0d_ram_addr", i), bus.ram_addr_o, vec[i].e_addr);
            chk($sformatf("v%0d_p0_accept", i), 32'(bus.p0_accept_o), vec[i].e_a0);
            chk($sformatf("v%0d_p0_ack", i), 32'(bus.p0_ack_o), vec[i].e_k0);
            chk($sformatf("v%0d_p1_accept", i), 32'(bus.p1_accept_o), vec[i].e_a1);
            chk($sformatf("v%0d_p1_ack", i), 32'(bus.p1_ack_o), vec[i].e_k1);
            chk($sformatf("v%0d_p0_rdata", i), bus.p0_read_data_o, vec[i].e_d0);
            chk($sformatf("v%0d_p1_rdata", i), bus.p1_read_data_o, vec[i].e_d1);
            if (vec[i].e_wr != 0) chk($sformatf("v%0d_ram_wdata", i), bus.ram_write_data_o, 32'hB1B1);
            next_cycle();
        end

        // Turnaround: last ack in M, IDLE in M+1, next forward in M+2.
        drive(1'b1, 1'b0, 4'h0, 1'b0, 1'b1, 32'h21); #4;
        chk("turn_m_ack", 32'(bus.p0_ack_o), 1);
        next_cycle();
        drive(1'b1, 1'b0, 4'h0, 1'b1, 1'b0, 32'h0); #4;
        chk("turn_m1_idle", 32'(bus.ram_rd_o), 0);
        next_cycle();
        #4;
        chk("turn_m2_fwd", 32'(bus.ram_rd_o), 1);
        next_cycle();
        drive(1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 32'h0); #4;
        chk("turn_drain_ack", 32'(bus.p0_ack_o), 1);
        next_cycle();

        // Four-beat read, acks three cycles after each accept.
        bus.p0_len_i = 8'd3;
        beats = 0; acks = 0; p1_acks = 0; first_fwd = -1; sh = '0;
        for (int c = 0; c < 30 && acks < 4; c++) begin
            drive(beats < 4, 1'b0, 4'h0, 1'b1, sh[2], 32'hC0 + 32'(acks));
            #4;
            taken = bus.ram_rd_o & bus.ram_accept_i;
            if (taken && first_fwd < 0) first_fwd = c;
            if (taken) beats++;
            if (bus.p0_ack_o) begin
                chk($sformatf("burst4_rdata%0d", acks), bus.p0_read_data_o, 32'hC0 + 32'(acks));
                acks++;
            end
            if (bus.p1_ack_o) p1_acks++;
            sh = {sh[1:0], taken};
            next_cycle();
        end
        chk("burst4_first_fwd", 32'(first_fwd), 1);
        chk("burst4_beats", 32'(beats), 4);
        chk("burst4_acks", 32'(acks), 4);
        chk("burst4_p1_acks", 32'(p1_acks), 0);

        // Saturation: 16-beat read with no acks stalls at 15 in flight.
        bus.p0_len_i = 8'd15;
        beats = 0;
        for (int c = 0; c < 20; c++) begin
            drive(1'b1, 1'b0, 4'h0, 1'b1, 1'b0, 32'h0); #4;
            if (bus.ram_rd_o) beats++;
            next_cycle();
        end
        chk("sat_beats", 32'(beats), 15);
        drive(1'b1, 1'b0, 4'h0, 1'b1, 1'b0, 32'h0); #4;
        chk("sat_stall_rd", 32'(bus.ram_rd_o), 0);
        next_cycle();
        drive(1'b1, 1'b0, 4'h0, 1'b1, 1'b1, 32'h0); #4;
        chk("sat_ack_rd", 32'(bus.ram_rd_o), 0);
        chk("sat_ack_p0", 32'(bus.p0_ack_o), 1);
        next_cycle();
        acks = 0;
        for (int c = 0; c < 20; c++) begin
            drive(beats < 16, 1'b0, 4'h0, 1'b1, 1'b1, 32'h0); #4;
            if (bus.ram_rd_o) beats++;
            if (bus.p0_ack_o) acks++;
            next_cycle();
        end
        chk("sat_total_beats", 32'(beats), 16);
        chk("sat_tail_acks", 32'(acks), 15);

        // Reset mid-burst with two beats in flight.
        bus.p0_len_i = 8'd3;
        drive(1'b1, 1'b0, 4'h0, 1'b1, 1'b0, 32'h0);
        repeat (3) next_cycle();
        arstn = 1'b0;
        drive(1'b1, 1'b0, 4'h0, 1'b1, 1'b1, 32'h77);
        next_cycle();
        arstn = 1'b1; #4;
        chk("rst_mid_ram_rd", 32'(bus.ram_rd_o), 0);
        chk("rst_mid_ram_addr", bus.ram_addr_o, 0);
        chk("rst_mid_late_ack", 32'(bus.p0_ack_o), 0);
        chk("rst_mid_rdata", bus.p0_read_data_o, 0);
        next_cycle();
        drive(1'b1, 1'b0, 4'h0, 1'b1, 1'b0, 32'h0); #4;
        chk("rst_regrant_rd", 32'(bus.ram_rd_o), 1);
        chk("rst_regrant_acc", 32'(bus.p0_accept_o), 1);
        next_cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
